mem_arbiter: RTL and testbench

- Sits between the instruction-fetch unit, the load/store buffer and the single byte-wide RAM/IO port.
- Arbitrates between the two requesters and splits each granted access into byte transactions on the external port: 1, 2 or 4 bytes, little-endian.
- Returns the assembled read data, or store completion, with a one-cycle done pulse.
- Handles pipeline flush and IO back-pressure.

---
 rtl/mem_arbiter_if.sv | 46 ++++
 rtl/mem_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester and byte-wide RAM/IO bus bundle for mem_arbiter
// Purpose: groups the fetch port, the load/store port and the external byte port
//          so they travel together as one module port.
// Signals:
//   if_req, if_addr, if_done, if_data           instruction-fetch handshake (word reads)
//   ls_req, ls_we, ls_width, ls_addr, ls_wdata,
//   ls_done, ls_rdata                           load/store handshake
//   mem_din, mem_dout, mem_a, mem_wr            byte-wide RAM/IO port
//   io_buffer_full                              IO output back-pressure
// Modports:
//   master  arbiter side (owns the RAM port, answers the requesters)
//   slave   requesters and RAM side
interface mem_arbiter_if #(
   parameter int ADDR_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_done;
   logic [31:0]       if_data;

   logic              ls_req;
   logic              ls_we;
   logic [1:0]        ls_width;
   logic [ADDR_W-1:0] ls_addr;
   logic [31:0]       ls_wdata;
   logic              ls_done;
   logic [31:0]       ls_rdata;

   logic [7:0]        mem_din;
   logic [7:0]        mem_dout;
   logic [ADDR_W-1:0] mem_a;
   logic              mem_wr;
   logic              io_buffer_full;

   modport master (
      input  if_req, if_addr, ls_req, ls_we, ls_width, ls_addr, ls_wdata,
             mem_din, io_buffer_full,
      output if_done, if_data, ls_done, ls_rdata, mem_dout, mem_a, mem_wr
   );

   modport slave (
      output if_req, if_addr, ls_req, ls_we, ls_width, ls_addr, ls_wdata,
             mem_din, io_buffer_full,
      input  if_done, if_data, ls_done, ls_rdata, mem_dout, mem_a, mem_wr
   );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch / load-store arbiter onto a single byte-wide RAM/IO port
// Purpose: grants one of two requesters (fetch, load/store), splits the access into
//          1, 2 or 4 little-endian byte transactions and returns the assembled word
//          or store completion with a one-cycle done pulse.
// Ports:
//   clk_in    system clock
//   rst_in    synchronous active-low reset
//   rdy_in    global ready; low freezes everything and suppresses mem_wr
//   clear_in  pipeline flush; aborts reads, lets stores finish
//   bus       mem_arbiter_if.master (requester handshakes and RAM/IO byte port)
// Configuration:
//   MEM_ARB_IO_STALL_EN  when defined, stores to IO space (addr[17:16] == IO_HI)
//                        stall while io_buffer_full is high; otherwise it is ignored.
module mem_arbiter #(
   parameter int         ADDR_W = 32,
   parameter logic [1:0] IO_HI  = 2'b11
) (
   input  logic          clk_in,
   input  logic          rst_in,
   input  logic          rdy_in,
   input  logic          clear_in,
   mem_arbiter_if.master bus
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_IF_RD = 2'd1;
   localparam logic [1:0] S_LS_RD = 2'd2;
   localparam logic [1:0] S_LS_WR = 2'd3;

   logic [1:0]        state;
   logic [2:0]        cnt;        // reads: cycles spent in state; writes: byte index on the bus
   logic [2:0]        n_q;        // bytes in the current access
   logic              last_ls;    // 1 when load/store received the most recent grant
   logic              io_q;       // latched "address is in IO space"
   logic [31:0]       rd_buf;
   logic [31:0]       rd_next;
   logic [31:0]       wbuf;       // store bytes still to be sent, next one in [7:0]
   logic [ADDR_W-1:0] mem_a_q;
   logic [7:0]        mem_dout_q;
   logic              wr_q;
   logic              if_done_q;
   logic              ls_done_q;
   logic [31:0]       if_data_q;
   logic [31:0]       ls_rdata_q;
   logic              stall;
   logic              grant_if;

   function automatic logic [2:0] width_bytes(input logic [1:0] w);
      case (w)
         2'd0:    return 3'd1;
         2'd1:    return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

`ifdef MEM_ARB_IO_STALL_EN
   assign stall = (state == S_LS_WR) && io_q && bus.io_buffer_full;
`else
   logic unused_io;
   assign stall     = 1'b0;
   assign unused_io = io_q ^ bus.io_buffer_full;
`endif

   // Tie goes to whichever side did not win last time.
   assign grant_if = bus.if_req && (!bus.ls_req || last_ls);

   // The byte arriving now belongs to the address presented in the previous
   // active cycle, i.e. byte index cnt-1.
   always_comb begin
      rd_next = rd_buf;
      case (cnt)
         3'd1:    rd_next[7:0]   = bus.mem_din;
         3'd2:    rd_next[15:8]  = bus.mem_din;
         3'd3:    rd_next[23:16] = bus.mem_din;
         3'd4:    rd_next[31:24] = bus.mem_din;
         default: rd_next = rd_buf;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         state      <= S_IDLE;
         cnt        <= '0;
         n_q        <= '0;
         last_ls    <= 1'b1;
         io_q       <= 1'b0;
         rd_buf     <= '0;
         wbuf       <= '0;
         mem_a_q    <= '0;
         mem_dout_q <= '0;
         wr_q       <= 1'b0;
         if_done_q  <= 1'b0;
         ls_done_q  <= 1'b0;
         if_data_q  <= '0;
         ls_rdata_q <= '0;
      end else if (rdy_in) begin
         if_done_q <= 1'b0;
         ls_done_q <= 1'b0;
         case (state)
            S_IDLE: begin
               // Requests are ignored in a done cycle: the requester is still
               // dropping its req there.
               if (!clear_in && !if_done_q && !ls_done_q) begin
                  if (grant_if) begin
                     state   <= S_IF_RD;
                     last_ls <= 1'b0;
                     mem_a_q <= bus.if_addr;
                     n_q     <= 3'd4;
                     cnt     <= '0;
                     rd_buf  <= '0;
                  end else if (bus.ls_req) begin
                     last_ls <= 1'b1;
                     mem_a_q <= bus.ls_addr;
                     n_q     <= width_bytes(bus.ls_width);
                     cnt     <= '0;
                     rd_buf  <= '0;
                     io_q    <= (bus.ls_addr[17:16] == IO_HI);
                     if (bus.ls_we) begin
                        state      <= S_LS_WR;
                        wr_q       <= 1'b1;
                        mem_dout_q <= bus.ls_wdata[7:0];
                        wbuf       <= {8'd0, bus.ls_wdata[31:8]};
                     end else begin
                        state <= S_LS_RD;
                     end
                  end
               end
            end

            S_IF_RD, S_LS_RD: begin
               if (clear_in) begin
                  state   <= S_IDLE;
                  mem_a_q <= '0;
               end else begin
                  rd_buf <= rd_next;
                  if (cnt == n_q) begin
                     state   <= S_IDLE;
                     mem_a_q <= '0;
                     if (state == S_IF_RD) begin
                        if_done_q <= 1'b1;
                        if_data_q <= rd_next;
                     end else begin
                        ls_done_q  <= 1'b1;
                        ls_rdata_q <= rd_next;
                     end
                  end else begin
                     cnt <= cnt + 3'd1;
                     // Stop advancing once the last address is on the bus.
                     if ((cnt + 3'd1) < n_q) begin
                        mem_a_q <= mem_a_q + ADDR_W'(1);
                     end
                  end
               end
            end

            S_LS_WR: begin
               // clear_in is deliberately ignored: stores only issue at commit.
               if (!stall) begin
                  if ((cnt + 3'd1) == n_q) begin
                     state     <= S_IDLE;
                     wr_q      <= 1'b0;
                     mem_a_q   <= '0;
                     ls_done_q <= 1'b1;
                  end else begin
                     cnt        <= cnt + 3'd1;
                     mem_a_q    <= mem_a_q + ADDR_W'(1);
                     mem_dout_q <= wbuf[7:0];
                     wbuf       <= {8'd0, wbuf[31:8]};
                  end
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.mem_a    = mem_a_q;
   assign bus.mem_dout = mem_dout_q;
   assign bus.mem_wr   = wr_q && rdy_in && !stall;
   assign bus.if_done  = if_done_q;
   assign bus.if_data  = if_data_q;
   assign bus.ls_done  = ls_done_q;
   assign bus.ls_rdata = ls_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter with a byte RAM model
module tb_mem_arbiter;

   localparam int MAXC = 24;

   logic clk_in;
   logic rst_in;
   logic rdy_in;
   logic clear_in;

   mem_arbiter_if #(.ADDR_W(32)) bus ();

   mem_arbiter #(.ADDR_W(32), .IO_HI(2'b11)) dut (
      .clk_in   (clk_in),
      .rst_in   (rst_in),
      .rdy_in   (rdy_in),
      .clear_in (clear_in),
      .bus      (bus.master)
   );

   int nchecks;
   int nerrs;

   logic [7:0]  ram  [logic [31:0]];
   logic [7:0]  gold [logic [31:0]];
   logic [39:0] wlog [$];

   logic [31:0] a_tr    [0:MAXC-1];
   bit          wr_tr   [0:MAXC-1];
   bit          zero_tr [0:MAXC-1];

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   function automatic logic [7:0] dflt(input logic [31:0] a);
      return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'hA5;
   endfunction

   function automatic logic [7:0] ram_rd(input logic [31:0] a);
      if (ram.exists(a)) return ram[a];
      return dflt(a);
   endfunction

   function automatic logic [7:0] gold_rd(input logic [31:0] a);
      if (gold.exists(a)) return gold[a];
      return dflt(a);
   endfunction

   function automatic logic [31:0] gold_word(input logic [31:0] a, input int n);
      logic [31:0] v;
      v = '0;
      for (int k = 0; k < n; k++) v = v | (32'(gold_rd(a + 32'(k))) << (8 * k));
      return v;
   endfunction

   // RAM: read data registered, frozen while rdy_in is low.
   always @(posedge clk_in) begin
      if (rdy_in) bus.mem_din <= ram_rd(bus.mem_a);
      if (bus.mem_wr) begin
         ram[bus.mem_a] = bus.mem_dout;
         wlog.push_back({bus.mem_a, bus.mem_dout});
      end
   end

   task automatic preload(input logic [31:0] a, input logic [7:0] b);
      ram[a]  = b;
      gold[a] = b;
   endtask

   // One access from one requester; cycle 0 is the first cycle req is high.
   task automatic xact(input bit is_if, input bit we, input logic [1:0] w,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input int pause_at, input int pause_len,
                       input int full_at, input int full_len,
                       input int clear_at, input int rst_at,
                       output int done_cyc, output logic [31:0] data);
      done_cyc = -1;
      data     = '0;
      wlog.delete();
      for (int c = 0; c < MAXC; c++) begin
         @(posedge clk_in);
         #1;
         if (c == 0) begin
            if (is_if) begin
               bus.if_req  = 1'b1;
               bus.if_addr = addr;
            end else begin
               bus.ls_req   = 1'b1;
               bus.ls_we    = we;
               bus.ls_width = w;
               bus.ls_addr  = addr;
               bus.ls_wdata = wdata;
            end
         end
         rdy_in             = !(c >= pause_at && c < pause_at + pause_len);
         bus.io_buffer_full = (c >= full_at && c < full_at + full_len);
         clear_in           = (c == clear_at);
         rst_in             = !(c == rst_at);
         if ((c == clear_at && clear_at > 0 && !we) || c == rst_at) begin
            bus.if_req = 1'b0;
            bus.ls_req = 1'b0;
         end
         @(negedge clk_in);
         a_tr[c]    = bus.mem_a;
         wr_tr[c]   = bus.mem_wr;
         zero_tr[c] = (bus.mem_a == 0) && (bus.mem_dout == 0) && !bus.mem_wr &&
                      !bus.if_done && (bus.if_data == 0) && !bus.ls_done &&
                      (bus.ls_rdata == 0);
         if (is_if ? bus.if_done : bus.ls_done) begin
            done_cyc   = c;
            data       = is_if ? bus.if_data : bus.ls_rdata;
            bus.if_req = 1'b0;
            bus.ls_req = 1'b0;
            break;
         end
      end
      rdy_in             = 1'b1;
      bus.io_buffer_full = 1'b0;
      clear_in           = 1'b0;
      rst_in             = 1'b1;
   endtask

   task automatic test_reset;
      rst_in = 1'b0;
      repeat (3) @(posedge clk_in);
      @(negedge clk_in);
      nchecks++; if (bus.mem_a !== 32'h0)    begin nerrs++; $display("FAIL reset_mem_a got %h exp 0", bus.mem_a); end
      nchecks++; if (bus.mem_dout !== 8'h0)  begin nerrs++; $display("FAIL reset_mem_dout got %h exp 0", bus.mem_dout); end
      nchecks++; if (bus.mem_wr !== 1'b0)    begin nerrs++; $display("FAIL reset_mem_wr got %b exp 0", bus.mem_wr); end
      nchecks++; if (bus.if_done !== 1'b0)   begin nerrs++; $display("FAIL reset_if_done got %b exp 0", bus.if_done); end
      nchecks++; if (bus.if_data !== 32'h0)  begin nerrs++; $display("FAIL reset_if_data got %h exp 0", bus.if_data); end
      nchecks++; if (bus.ls_done !== 1'b0)   begin nerrs++; $display("FAIL reset_ls_done got %b exp 0", bus.ls_done); end
      nchecks++; if (bus.ls_rdata !== 32'h0) begin nerrs++; $display("FAIL reset_ls_rdata got %h exp 0", bus.ls_rdata); end
      rst_in = 1'b1;
   endtask

   // Both sides request continuously; grants must alternate, IF first after reset.
   task automatic test_arbitration;
      int          ev_cyc [$];
      bit          ev_if  [$];
      logic [31:0] ev_dat [$];
      logic [31:0] ia, la, ma_if, ma_ls, exp_d;
      int          t, exp_c;
      bit          win_if;
      ia = 32'h0;
      la = 32'h200;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk_in);
         #1;
         bus.if_req   = 1'b1;
         bus.if_addr  = ia;
         bus.ls_req   = 1'b1;
         bus.ls_we    = 1'b0;
         bus.ls_width = 2'd0;
         bus.ls_addr  = la;
         @(negedge clk_in);
         if (bus.if_done) begin
            ev_cyc.push_back(c); ev_if.push_back(1'b1); ev_dat.push_back(bus.if_data);
            bus.if_req = 1'b0;
            ia = ia + 32'd4;
         end
         if (bus.ls_done) begin
            ev_cyc.push_back(c); ev_if.push_back(1'b0); ev_dat.push_back(bus.ls_rdata);
            bus.ls_req = 1'b0;
            la = la + 32'd1;
         end
      end
      @(posedge clk_in);
      #1;
      bus.if_req = 1'b0;
      bus.ls_req = 1'b0;
      repeat (10) @(posedge clk_in);
      nchecks++;
      if (ev_cyc.size() < 4) begin
         nerrs++; $display("FAIL arb_events got %0d exp >=4", ev_cyc.size());
      end else begin
         t = 0; win_if = 1'b1; ma_if = 32'h0; ma_ls = 32'h200;
         for (int e = 0; e < 4; e++) begin
            exp_c = t + (win_if ? 6 : 3);
            exp_d = win_if ? gold_word(ma_if, 4) : gold_word(ma_ls, 1);
            nchecks++;
            if (ev_cyc[e] !== exp_c || ev_if[e] !== win_if) begin
               nerrs++;
               $display("FAIL arb_order[%0d] got if=%b cyc=%0d exp if=%b cyc=%0d", e, ev_if[e], ev_cyc[e], win_if, exp_c);
            end
            nchecks++;
            if (ev_dat[e] !== exp_d) begin
               nerrs++; $display("FAIL arb_data[%0d] got %h exp %h", e, ev_dat[e], exp_d);
            end
            if (win_if) ma_if = ma_if + 32'd4; else ma_ls = ma_ls + 32'd1;
            t = exp_c + 1;
            win_if = !win_if;
         end
      end
   endtask

   task automatic test_word_fetch;
      int dc; logic [31:0] d;
      preload(32'h100, 8'h13); preload(32'h101, 8'h05);
      preload(32'h102, 8'h00); preload(32'h103, 8'h00);
      xact(1'b1, 1'b0, 2'd2, 32'h100, 32'h0, -1, 0, -1, 0, -1, -1, dc, d);
      nchecks++; if (dc !== 6) begin nerrs++; $display("FAIL fetch_done_cycle got %0d exp 6", dc); end
      nchecks++; if (d !== 32'h00000513) begin nerrs++; $display("FAIL fetch_data got %h exp 00000513", d); end
      for (int k = 0; k < 4; k++) begin
         nchecks++;
         if (a_tr[k+1] !== 32'h100 + 32'(k) || wr_tr[k+1] !== 1'b0) begin
            nerrs++; $display("FAIL fetch_addr[%0d] got %h wr=%b exp %h wr=0", k, a_tr[k+1], wr_tr[k+1], 32'h100 + 32'(k));
         end
      end
      nchecks++; if (a_tr[6] !== 32'h0) begin nerrs++; $display("FAIL fetch_addr_idle got %h exp 0", a_tr[6]); end
   endtask

   task automatic test_half;
      int dc; logic [31:0] d;
      xact(1'b0, 1'b1, 2'd1, 32'h1FFFF, 32'h0001ABCD, -1, 0, -1, 0, -1, -1, dc, d);
      gold[32'h1FFFF] = 8'hCD; gold[32'h20000] = 8'hAB;
      nchecks++; if (dc !== 3) begin nerrs++; $display("FAIL half_store_done got %0d exp 3", dc); end
      nchecks++;
      if (wlog.size() != 2) begin
         nerrs++; $display("FAIL half_store_count got %0d exp 2", wlog.size());
      end else begin
         nchecks++; if (wlog[0] !== {32'h1FFFF, 8'hCD}) begin nerrs++; $display("FAIL half_store_b0 got %h exp 1ffffcd", wlog[0]); end
         nchecks++; if (wlog[1] !== {32'h20000, 8'hAB}) begin nerrs++; $display("FAIL half_store_b1 got %h exp 20000ab", wlog[1]); end
      end
      preload(32'h7, 8'h34); preload(32'h8, 8'h12);
      xact(1'b0, 1'b0, 2'd1, 32'h7, 32'h0, -1, 0, -1, 0, -1, -1, dc, d);
      nchecks++; if (dc !== 4) begin nerrs++; $display("FAIL half_load_done got %0d exp 4", dc); end
      nchecks++; if (d !== 32'h00001234) begin nerrs++; $display("FAIL half_load_data got %h exp 00001234", d); end
   endtask

   task automatic test_clear;
      int dc; logic [31:0] d;
      xact(1'b0, 1'b0, 2'd2, 32'h40, 32'h0, -1, 0, -1, 0, 3, -1, dc, d);
      nchecks++; if (dc !== -1) begin nerrs++; $display("FAIL clear_load_done got %0d exp none", dc); end
      nchecks++; if (a_tr[4] !== 32'h0) begin nerrs++; $display("FAIL clear_load_addr got %h exp 0", a_tr[4]); end
      xact(1'b0, 1'b1, 2'd2, 32'h80, 32'hDEADBEEF, -1, 0, -1, 0, 2, -1, dc, d);
      for (int k = 0; k < 4; k++) gold[32'h80 + 32'(k)] = 8'(32'hDEADBEEF >> (8 * k));
      nchecks++; if (dc !== 5) begin nerrs++; $display("FAIL clear_store_done got %0d exp 5", dc); end
      nchecks++;
      if (wlog.size() != 4) begin
         nerrs++; $display("FAIL clear_store_count got %0d exp 4", wlog.size());
      end else begin
         nchecks++; if (wlog[3] !== {32'h83, 8'hDE}) begin nerrs++; $display("FAIL clear_store_b3 got %h exp 83de", wlog[3]); end
      end
      // Flush while the request is first seen in IDLE: grant slips one cycle.
      xact(1'b1, 1'b0, 2'd2, 32'h100, 32'h0, -1, 0, -1, 0, 0, -1, dc, d);
      nchecks++; if (dc !== 7) begin nerrs++; $display("FAIL clear_idle_done got %0d exp 7", dc); end
      nchecks++; if (d !== 32'h00000513) begin nerrs++; $display("FAIL clear_idle_data got %h exp 00000513", d); end
   endtask

   task automatic test_io_stall;
      int dc; logic [31:0] d; int exp_c;
      xact(1'b0, 1'b1, 2'd0, 32'h30000, 32'h5A, -1, 0, 1, 3, -1, -1, dc, d);
      gold[32'h30000] = 8'h5A;
`ifdef MEM_ARB_IO_STALL_EN
      exp_c = 5;
      nchecks++;
      if (wr_tr[1] || wr_tr[2] || wr_tr[3] || !wr_tr[4]) begin
         nerrs++; $display("FAIL io_stall_wr got %b%b%b%b exp 0001", wr_tr[1], wr_tr[2], wr_tr[3], wr_tr[4]);
      end
`else
      exp_c = 2;
      nchecks++; if (wr_tr[1] !== 1'b1) begin nerrs++; $display("FAIL io_nostall_wr got %b exp 1", wr_tr[1]); end
`endif
      nchecks++; if (dc !== exp_c) begin nerrs++; $display("FAIL io_store_done got %0d exp %0d", dc, exp_c); end
      nchecks++;
      if (wlog.size() != 1 || wlog[0] !== {32'h30000, 8'h5A}) begin
         nerrs++; $display("FAIL io_store_write got n=%0d exp single 300005a", wlog.size());
      end
      xact(1'b0, 1'b1, 2'd0, 32'h20000, 32'h77, -1, 0, 1, 3, -1, -1, dc, d);
      gold[32'h20000] = 8'h77;
      nchecks++; if (dc !== 2) begin nerrs++; $display("FAIL nonio_store_done got %0d exp 2", dc); end
   endtask

   task automatic test_pause_reset;
      int dc; logic [31:0] d;
      preload(32'h300, 8'h11); preload(32'h301, 8'h22);
      preload(32'h302, 8'h33); preload(32'h303, 8'h44);
      xact(1'b1, 1'b0, 2'd2, 32'h300, 32'h0, 2, 2, -1, 0, -1, -1, dc, d);
      nchecks++; if (dc !== 8) begin nerrs++; $display("FAIL pause_done got %0d exp 8", dc); end
      nchecks++; if (d !== 32'h44332211) begin nerrs++; $display("FAIL pause_data got %h exp 44332211", d); end
      nchecks++; if (wr_tr[2] !== 1'b0) begin nerrs++; $display("FAIL pause_wr got %b exp 0", wr_tr[2]); end
      xact(1'b0, 1'b1, 2'd2, 32'h9000, 32'hCAFEF00D, -1, 0, -1, 0, -1, 2, dc, d);
      nchecks++; if (dc !== -1) begin nerrs++; $display("FAIL rst_store_done got %0d exp none", dc); end
      nchecks++; if (zero_tr[3] !== 1'b1) begin nerrs++; $display("FAIL rst_outputs_zero got %b exp 1", zero_tr[3]); end
   endtask

   task automatic test_random;
      for (int i = 0; i < 24; i++) begin
         bit          is_if, we;
         logic [1:0]  w;
         logic [31:0] a, d, exp_d, got;
         int          n, pl, pa, dc, exp_c;
         is_if = ($urandom_range(0, 2) == 0);
         we    = !is_if && ($urandom_range(0, 1) == 1);
         w     = is_if ? 2'd2 : 2'($urandom_range(0, 3));
         n     = (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
         a     = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFFF - 32'($urandom_range(0, 2))) : $urandom;
         d     = $urandom;
         pl    = $urandom_range(0, 2);
         pa    = $urandom_range(1, n);
         exp_d = gold_word(a, n);
         exp_c = (we ? n + 1 : n + 2) + pl;
         xact(is_if, we, w, a, d, pa, pl, -1, 0, -1, -1, dc, got);
         nchecks++;
         if (dc !== exp_c) begin nerrs++; $display("FAIL rnd%0d_done got %0d exp %0d", i, dc, exp_c); end
         if (we) begin
            nchecks++;
            if (wlog.size() != n) begin
               nerrs++; $display("FAIL rnd%0d_wcount got %0d exp %0d", i, wlog.size(), n);
            end
            for (int k = 0; k < n && k < wlog.size(); k++) begin
               nchecks++;
               if (wlog[k] !== {a + 32'(k), 8'(d >> (8 * k))}) begin
                  nerrs++; $display("FAIL rnd%0d_wbyte%0d got %h exp %h", i, k, wlog[k], {a + 32'(k), 8'(d >> (8 * k))});
               end
            end
            for (int k = 0; k < n; k++) gold[a + 32'(k)] = 8'(d >> (8 * k));
         end else begin
            nchecks++;
            if (got !== exp_d) begin nerrs++; $display("FAIL rnd%0d_rdata got %h exp %h", i, got, exp_d); end
            if (pl == 0) begin
               for (int k = 0; k < n; k++) begin
                  nchecks++;
                  if (a_tr[k+1] !== a + 32'(k)) begin
                     nerrs++; $display("FAIL rnd%0d_addr%0d got %h exp %h", i, k, a_tr[k+1], a + 32'(k));
                  end
               end
            end
         end
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      nchecks            = 0;
      nerrs              = 0;
      rst_in             = 1'b0;
      rdy_in             = 1'b1;
      clear_in           = 1'b0;
      bus.if_req         = 1'b0;
      bus.if_addr        = '0;
      bus.ls_req         = 1'b0;
      bus.ls_we          = 1'b0;
      bus.ls_width       = 2'd0;
      bus.ls_addr        = '0;
      bus.ls_wdata       = '0;
      bus.io_buffer_full = 1'b0;
      test_reset();
      test_arbitration();
      test_word_fetch();
      test_half();
      test_clear();
      test_io_stall();
      test_pause_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
      $finish;
   end

endmodule
